// File: rtl/int_return_unit.sv
// int_return_unit: CPU-side responder for the interrupt controller.
// On a request it saves the return address and redirects the PC to the
// vector address. On a return-from-interrupt it restores the saved address
// and pulses fin back to the controller.
// Optional feature macro: INT_NEST_EN enables nesting with a DEPTH-entry
// LIFO return stack and a sticky overflow flag. Without it, a single return
// register is used and ovf is tied low.
module int_return_unit #(
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_interrup,
    input  logic [AW-1:0] dir,
    input  logic [AW-1:0] pc_next,
    input  logic          reti,
    output logic          pc_sel,
    output logic [AW-1:0] pc_out,
    output logic          fin,
    output logic          in_isr,
    output logic          ovf
);

`ifdef INT_NEST_EN
    localparam bit NEST_EN = 1'b1;
`else
    localparam bit NEST_EN = 1'b0;
`endif
    localparam int DEPTH_EFF = NEST_EN ? DEPTH : 1;
    localparam int SPW       = $clog2(DEPTH_EFF + 1);

    typedef enum logic [1:0] {IDLE, ENTER, SERVICE, EXIT} state_t;

    state_t          state_reg;
    logic [SPW-1:0]  sp_reg;
    logic [AW-1:0]   stack_mem [DEPTH_EFF];
    logic            pc_sel_reg;
    logic [AW-1:0]   pc_out_reg;
    logic            fin_reg;
    logic            in_isr_reg;

    logic            stack_full;
    logic            stack_empty;
    logic            take_req;
    logic            push;
    logic            pop;
    logic [SPW-1:0]  sp_dec;
    logic [AW-1:0]   stack_top;

    // Request acceptance, push/pop decisions and top-of-stack read
    always_comb begin
        stack_full  = (sp_reg == SPW'(DEPTH_EFF));
        stack_empty = (sp_reg == '0);
        // reti has priority over a request arriving in SERVICE
        take_req    = s_interrup &&
                      ((state_reg == IDLE) ||
                       (NEST_EN && (state_reg == SERVICE) && !reti));
        push        = take_req && !stack_full;
        pop         = (state_reg == SERVICE) && reti;
        sp_dec      = sp_reg - SPW'(1);
        stack_top   = '0;
        for (int i = 0; i < DEPTH_EFF; i++) begin
            if (sp_dec == SPW'(i)) begin
                stack_top = stack_mem[i];
            end
        end
    end

    // Return-address storage: write the entry at the current stack pointer
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH_EFF; i++) begin
            if (push && (sp_reg == SPW'(i))) begin
                stack_mem[i] <= pc_next;
            end
        end
    end

    // Control FSM with registered outputs; redirect outputs default to idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            sp_reg     <= '0;
            pc_sel_reg <= 1'b0;
            pc_out_reg <= '0;
            fin_reg    <= 1'b0;
            in_isr_reg <= 1'b0;
        end else begin
            pc_sel_reg <= 1'b0;
            pc_out_reg <= '0;
            fin_reg    <= 1'b0;
            if (push) begin
                sp_reg     <= sp_reg + SPW'(1);
                pc_sel_reg <= 1'b1;
                pc_out_reg <= dir;
                in_isr_reg <= 1'b1;
                state_reg  <= ENTER;
            end else if (pop) begin
                sp_reg     <= sp_dec;
                pc_sel_reg <= 1'b1;
                pc_out_reg <= stack_top;
                fin_reg    <= 1'b1;
                in_isr_reg <= (sp_dec != '0);
                state_reg  <= EXIT;
            end else begin
                case (state_reg)
                    IDLE: begin
                        in_isr_reg <= 1'b0;
                    end
                    ENTER: begin
                        in_isr_reg <= 1'b1;
                        state_reg  <= SERVICE;
                    end
                    SERVICE: begin
                        in_isr_reg <= 1'b1;
                    end
                    EXIT: begin
                        in_isr_reg <= !stack_empty;
                        state_reg  <= stack_empty ? IDLE : SERVICE;
                    end
                    default: begin
                        in_isr_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef INT_NEST_EN
    logic ovf_reg;

    // Sticky overflow: a request found the stack full and was dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_reg <= 1'b0;
        end else if (take_req && stack_full) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign pc_sel = pc_sel_reg;
    assign pc_out = pc_out_reg;
    assign fin    = fin_reg;
    assign in_isr = in_isr_reg;

endmodule

// File: tb/tb_int_return_unit.sv
// Directed testbench for int_return_unit. Inputs change 1 ns after the
// rising edge; outputs are checked in the same window, after the edge that
// produced them. With INT_NEST_EN defined, the nesting scenario runs with
// DEPTH=2 instead of the long-request scenario.
module tb_int_return_unit;

    localparam int AW = 10;
`ifdef INT_NEST_EN
    localparam int TB_DEPTH = 2;
`else
    localparam int TB_DEPTH = 4;
`endif

    logic          clk;
    logic          reset;
    logic          s_interrup;
    logic [AW-1:0] dir;
    logic [AW-1:0] pc_next;
    logic          reti;
    logic          pc_sel;
    logic [AW-1:0] pc_out;
    logic          fin;
    logic          in_isr;
    logic          ovf;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    int_return_unit #(
        .AW    (AW),
        .DEPTH (TB_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_interrup (s_interrup),
        .dir        (dir),
        .pc_next    (pc_next),
        .reti       (reti),
        .pc_sel     (pc_sel),
        .pc_out     (pc_out),
        .fin        (fin),
        .in_isr     (in_isr),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [AW-1:0] d,
                         input logic [AW-1:0] pcn, input logic ret);
        s_interrup = req;
        dir        = d;
        pc_next    = pcn;
        reti       = ret;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0);

        // Reset state
        tick();
        tick();
        check("rst_pc_sel", 32'(pc_sel), 0);
        check("rst_pc_out", 32'(pc_out), 0);
        check("rst_fin",    32'(fin),    0);
        check("rst_in_isr", 32'(in_isr), 0);
        check("rst_ovf",    32'(ovf),    0);
        reset = 1'b1;
        tick();

        // Stray return in IDLE
        drive(1'b0, '0, 10'd55, 1'b1);
        tick();
        check("stray_pc_sel", 32'(pc_sel), 0);
        check("stray_fin",    32'(fin),    0);
        check("stray_pc_out", 32'(pc_out), 0);
        drive(1'b0, '0, '0, 1'b0);
        tick();

        // Basic entry / exit
        drive(1'b1, 10'd824, 10'd100, 1'b0);
        tick();
        check("enter_pc_sel", 32'(pc_sel), 1);
        check("enter_pc_out", 32'(pc_out), 824);
        check("enter_in_isr", 32'(in_isr), 1);
        check("enter_fin",    32'(fin),    0);
        drive(1'b0, '0, 10'd101, 1'b0);
        tick();
        check("svc_pc_sel", 32'(pc_sel), 0);
        check("svc_pc_out", 32'(pc_out), 0);
        check("svc_in_isr", 32'(in_isr), 1);
        drive(1'b0, '0, 10'd102, 1'b1);
        tick();
        check("exit_pc_sel", 32'(pc_sel), 1);
        check("exit_pc_out", 32'(pc_out), 100);
        check("exit_fin",    32'(fin),    1);
        check("exit_in_isr", 32'(in_isr), 0);
        drive(1'b0, '0, 10'd100, 1'b0);
        tick();
        check("post_fin",    32'(fin),    0);
        check("post_pc_sel", 32'(pc_sel), 0);
        check("post_pc_out", 32'(pc_out), 0);

`ifndef INT_NEST_EN
        // Long request: held 3 cycles, only one ENTER cycle
        cnt = 0;
        drive(1'b1, 10'd874, 10'd300, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pc_sel) cnt++;
        end
        check("long_enter_cycles", 32'(cnt), 1);
        drive(1'b0, '0, 10'd301, 1'b1);
        tick();
        check("long_exit_fin",    32'(fin),    1);
        check("long_exit_pc_out", 32'(pc_out), 300);
        drive(1'b0, '0, 10'd300, 1'b0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (fin) cnt++;
        end
        check("long_extra_fin", 32'(cnt), 0);
        check("long_in_isr",    32'(in_isr), 0);
`endif

        // Collision in SERVICE: reti wins, request dropped
        drive(1'b1, 10'd824, 10'd500, 1'b0);
        tick();
        drive(1'b0, '0, 10'd501, 1'b0);
        tick();
        drive(1'b1, 10'd924, 10'd600, 1'b1);
        tick();
        check("coll_pc_sel", 32'(pc_sel), 1);
        check("coll_pc_out", 32'(pc_out), 500);
        check("coll_fin",    32'(fin),    1);
        drive(1'b0, '0, 10'd500, 1'b0);
        tick();
        check("coll_no_entry", 32'(pc_sel), 0);
        check("coll_pc_out0",  32'(pc_out), 0);
        check("coll_in_isr",   32'(in_isr), 0);
        check("coll_ovf",      32'(ovf),    0);

        // Asynchronous reset mid-ISR
        drive(1'b1, 10'd10, 10'd20, 1'b0);
        tick();
        drive(1'b0, '0, 10'd21, 1'b0);
        tick();
        check("mid_in_isr", 32'(in_isr), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_in_isr", 32'(in_isr), 0);
        check("async_pc_sel", 32'(pc_sel), 0);
        tick();
        reset = 1'b1;
        drive(1'b0, '0, 10'd22, 1'b1);
        tick();
        check("after_rst_fin",    32'(fin),    0);
        check("after_rst_pc_sel", 32'(pc_sel), 0);
        check("after_rst_pc_out", 32'(pc_out), 0);
        drive(1'b0, '0, '0, 1'b0);
        tick();

`ifdef INT_NEST_EN
        // Nesting with DEPTH=2: third request overflows
        drive(1'b1, 10'd824, 10'd100, 1'b0);
        tick();
        check("n1_pc_out", 32'(pc_out), 824);
        drive(1'b0, '0, 10'd101, 1'b0);
        tick();
        drive(1'b1, 10'd874, 10'd200, 1'b0);
        tick();
        check("n2_pc_out", 32'(pc_out), 874);
        check("n2_pc_sel", 32'(pc_sel), 1);
        drive(1'b0, '0, 10'd201, 1'b0);
        tick();
        drive(1'b1, 10'd924, 10'd300, 1'b0);
        tick();
        check("n3_dropped", 32'(pc_sel), 0);
        check("n3_ovf",     32'(ovf),    1);
        check("n3_in_isr",  32'(in_isr), 1);
        drive(1'b0, '0, 10'd301, 1'b0);
        tick();
        drive(1'b0, '0, 10'd202, 1'b1);
        tick();
        check("r1_pc_out", 32'(pc_out), 200);
        check("r1_fin",    32'(fin),    1);
        check("r1_in_isr", 32'(in_isr), 1);
        drive(1'b0, '0, 10'd201, 1'b0);
        tick();
        check("r1_gap_fin", 32'(fin), 0);
        drive(1'b0, '0, 10'd102, 1'b1);
        tick();
        check("r2_pc_out", 32'(pc_out), 100);
        check("r2_fin",    32'(fin),    1);
        check("r2_in_isr", 32'(in_isr), 0);
        drive(1'b0, '0, 10'd100, 1'b0);
        tick();
        check("nest_idle_pc_sel", 32'(pc_sel), 0);
        check("nest_ovf_sticky",  32'(ovf),    1);
        drive(1'b0, '0, 10'd100, 1'b1);
        tick();
        check("nest_idle_reti_fin", 32'(fin), 0);
        drive(1'b0, '0, '0, 1'b0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/int_return_unit.md
# int_return_unit

CPU-side responder for the interrupt controller's request interface. Accepts the controller's request pulse and 10-bit vector address, then saves the return address and steers the program counter to the vector. When the decoder flags a return-from-interrupt instruction, it restores the saved address and pulses `fin` back to the controller. Sits between the interrupt controller and the PC multiplexer of the monocycle core.

## Interface

Parameters:
- `AW`, 10, address width of PC, vector and return addresses.
- `DEPTH`, 4, return-stack entries. Used only with `INT_NEST_EN`; otherwise the depth is fixed at 1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_interrup`  in  1  interrupt request from the controller. Sampled on the rising edge.
- `dir`  in  AW  vector address. Valid only while `s_interrup`=1; may be X otherwise.
- `pc_next`  in  AW  sequential next-PC of the instruction executing this cycle. This is the return address.
- `reti`  in  1  decoder flag: the current instruction is return-from-interrupt.
- `pc_sel`  out  1  1 = PC mux selects `pc_out`.
- `pc_out`  out  AW  redirect target: the vector on entry, the return address on exit.
- `fin`  out  1  one-cycle pulse to the controller: ISR finished.
- `in_isr`  out  1  1 while at least one ISR is active.
- `ovf`  out  1  sticky flag: request dropped because the stack was full. Cleared only by reset.

## Operation

- States: IDLE, ENTER, SERVICE, EXIT. All outputs are registered.
- IDLE:
  - `s_interrup`=1 → push `pc_next`, latch `dir` into the vector register, go to ENTER.
  - `reti`=1 → ignored; no `fin` is produced.
- ENTER (exactly 1 cycle):
  - `pc_sel`=1, `pc_out`=latched vector.
  - Then go to SERVICE.
- SERVICE:
  - `reti`=1 → pop the top entry into `pc_out` and go to EXIT.
  - Without `INT_NEST_EN`, `s_interrup`=1 is ignored.
- EXIT (exactly 1 cycle):
  - `pc_sel`=1, `pc_out`=popped address, `fin`=1.
  - Next state is IDLE if the stack is empty, otherwise SERVICE.
- `in_isr`=1 in ENTER and SERVICE, and in EXIT when the stack is non-empty after the pop.
- Simultaneous `reti` and `s_interrup` in SERVICE: `reti` wins. The request is dropped and `ovf` is not set.
- Stack pointer is `$clog2(DEPTH+1)` bits wide. Push and pop are never issued in the same cycle.
- Outputs are held at their idle values (0) in IDLE and SERVICE. `pc_out` returns to 0 outside ENTER and EXIT.

## Timing

- Reset (asynchronous, `reset`=0):
  - State → IDLE, stack emptied.
  - `pc_sel`=0, `pc_out`=0, `fin`=0, `in_isr`=0, `ovf`=0.
  - Applies immediately, including mid-ISR. No `fin` is emitted for the aborted ISR.
- Entry latency: `s_interrup` high at edge k → `pc_sel`=1 and `pc_out`=vector during cycle k..k+1 → PC loads the vector at edge k+1.
- Exit latency: `reti` high at edge m → `pc_sel`=1, `pc_out`=return address and `fin`=1 during cycle m..m+1. `fin` is exactly one cycle wide.
- A `s_interrup` pulse wider than one cycle triggers only one entry. ENTER consumes the second cycle, and SERVICE ignores or nests per configuration.
- Minimum ISR length: `reti` is accepted at the first SERVICE edge, so entry-to-exit takes at least 2 cycles.

## Configuration

- `INT_NEST_EN` defined:
  - SERVICE also accepts `s_interrup`=1 (with `reti`=0): push `pc_next`, latch `dir`, go to ENTER.
  - The stack holds up to `DEPTH` entries, popped in LIFO order.
  - A request arriving when the stack holds `DEPTH` entries is dropped and sets `ovf`=1. State and stack are unchanged.
  - `fin` pulses on every EXIT.
- `INT_NEST_EN` undefined:
  - Single return register; requests in SERVICE are ignored.
  - `ovf` is tied to 0.

## Test plan

- Reset: hold `reset`=0 during an active ISR, then release → all outputs 0, state IDLE; a following `reti`=1 produces no `fin`.
- Basic entry/exit: `s_interrup`=1, `dir`=824, `pc_next`=100 for one cycle → next cycle `pc_sel`=1, `pc_out`=824. Then `reti`=1 → next cycle `pc_sel`=1, `pc_out`=100, `fin`=1 for 1 cycle, `in_isr`=0.
- Stray return: `reti`=1 in IDLE → `pc_sel`, `fin` and `pc_out` stay 0.
- Long request: `s_interrup` held 3 cycles with `dir`=874 (no nesting) → exactly one ENTER cycle; a single `reti` gives exactly one `fin`.
- Collision in SERVICE: `reti`=1 and `s_interrup`=1 with `dir`=924 in the same cycle → EXIT to the saved address, `fin`=1, no entry to 924, `ovf`=0.
- `INT_NEST_EN`, `DEPTH`=2: requests at `pc_next`=100 (`dir`=824), 200 (`dir`=874) and 300 (`dir`=924) → first two enter, third is dropped with `ovf`=1. Two `reti` → `pc_out`=200, then 100, each with a `fin` pulse; ends in IDLE.
